// File: rtl/triangle_scan_controller_pkg.sv
// Shared fixed-point types and helpers for the triangle pipeline.
package triangle_scan_controller_pkg;

  // Signed 16.16 fixed-point value.
  typedef logic signed [31:0] FixedPoint_t;

  localparam int unsigned FP_FRAC_BITS = 16;

  typedef struct packed {
    FixedPoint_t x;
    FixedPoint_t y;
    FixedPoint_t r;
    FixedPoint_t g;
    FixedPoint_t b;
  } vertex_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } scan_state_t;

  // Largest integer not above v.
  function automatic int fixed_point_floor_int(input FixedPoint_t v);
    return int'(v >>> FP_FRAC_BITS);
  endfunction

  // Smallest integer not below v.
  function automatic int fixed_point_ceil_int(input FixedPoint_t v);
    return fixed_point_floor_int(v) + ((v[FP_FRAC_BITS-1:0] != '0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/triangle_scan_controller_raster.sv
// Combinational triangle rasterizer: inclusive edge-function coverage test,
// flat shading with the mean of the three vertex colours.
module triangle_scan_controller_raster
  import triangle_scan_controller_pkg::*;
(
  input  vertex_t            i_v1,
  input  vertex_t            i_v2,
  input  vertex_t            i_v3,
  input  logic signed [31:0] i_x,
  input  logic signed [31:0] i_y,
  output logic [7:0]         o_r,
  output logic [7:0]         o_g,
  output logic [7:0]         o_b
);

  localparam int unsigned PW = 48;

  typedef logic signed [PW-1:0]   pfix_t;
  typedef logic signed [PW:0]     diff_t;
  typedef logic signed [2*PW+2:0] area_t;

  // Twice the signed area of (a, b, p); sign tells which side of a->b p lies on.
  function automatic area_t edge_fn(input pfix_t ax, input pfix_t ay,
                                    input pfix_t bx, input pfix_t by,
                                    input pfix_t px, input pfix_t py);
    diff_t ex, ey, qx, qy;
    area_t m0, m1;
    ex = diff_t'(bx) - diff_t'(ax);
    ey = diff_t'(by) - diff_t'(ay);
    qx = diff_t'(px) - diff_t'(ax);
    qy = diff_t'(py) - diff_t'(ay);
    m0 = area_t'(ex) * area_t'(qy);
    m1 = area_t'(ey) * area_t'(qx);
    return m0 - m1;
  endfunction

  // Mean of three fixed colours saturated to an 8-bit channel.
  function automatic logic [7:0] shade(input FixedPoint_t c1, input FixedPoint_t c2,
                                       input FixedPoint_t c3);
    logic signed [33:0] sum, avg;
    sum = 34'(c1) + 34'(c2) + 34'(c3);
    avg = sum / 34'sd3;
    if (avg < 0) return '0;
    if (avg >= (34'sd1 <<< FP_FRAC_BITS)) return 8'hff;
    return 8'(avg >>> 8);
  endfunction

  pfix_t px, py;
  area_t w0, w1, w2;
  logic  covered;

  // Coverage test and colour lookup for the sample point.
  always_comb begin
    px = pfix_t'(i_x) <<< FP_FRAC_BITS;
    py = pfix_t'(i_y) <<< FP_FRAC_BITS;
    w0 = edge_fn(pfix_t'(i_v2.x), pfix_t'(i_v2.y), pfix_t'(i_v3.x), pfix_t'(i_v3.y), px, py);
    w1 = edge_fn(pfix_t'(i_v3.x), pfix_t'(i_v3.y), pfix_t'(i_v1.x), pfix_t'(i_v1.y), px, py);
    w2 = edge_fn(pfix_t'(i_v1.x), pfix_t'(i_v1.y), pfix_t'(i_v2.x), pfix_t'(i_v2.y), px, py);
    covered = ((w0 >= 0) && (w1 >= 0) && (w2 >= 0)) ||
              ((w0 <= 0) && (w1 <= 0) && (w2 <= 0));
    o_r = '0;
    o_g = '0;
    o_b = '0;
    if (covered) begin
      o_r = shade(i_v1.r, i_v2.r, i_v3.r);
      o_g = shade(i_v1.g, i_v2.g, i_v3.g);
      o_b = shade(i_v1.b, i_v2.b, i_v3.b);
    end
  end

endmodule

// File: rtl/triangle_scan_controller.sv
// Latches a triangle, walks its clamped bounding box in raster order and
// streams rasterized pixels through a valid/ready output register.
module triangle_scan_controller
  import triangle_scan_controller_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter bit SKIP_BLACK = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  FixedPoint_t                 i_v1x,
  input  FixedPoint_t                 i_v1y,
  input  FixedPoint_t                 i_v1r,
  input  FixedPoint_t                 i_v1g,
  input  FixedPoint_t                 i_v1b,
  input  FixedPoint_t                 i_v2x,
  input  FixedPoint_t                 i_v2y,
  input  FixedPoint_t                 i_v2r,
  input  FixedPoint_t                 i_v2g,
  input  FixedPoint_t                 i_v2b,
  input  FixedPoint_t                 i_v3x,
  input  FixedPoint_t                 i_v3y,
  input  FixedPoint_t                 i_v3r,
  input  FixedPoint_t                 i_v3g,
  input  FixedPoint_t                 i_v3b,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pixel_valid,
  input  logic                        i_pixel_ready,
  output logic [$clog2(SCREEN_W)-1:0] o_pixel_x,
  output logic [$clog2(SCREEN_H)-1:0] o_pixel_y,
  output logic [7:0]                  o_pixel_r,
  output logic [7:0]                  o_pixel_g,
  output logic [7:0]                  o_pixel_b
);

  localparam int unsigned XW = $clog2(SCREEN_W);
  localparam int unsigned YW = $clog2(SCREEN_H);

  typedef logic [XW-1:0] xcoord_t;
  typedef logic [YW-1:0] ycoord_t;

  scan_state_t state, state_next;
  vertex_t     v1, v2, v3;
  xcoord_t     xmin, xmax, cur_x;
  ycoord_t     ymax, cur_y;

  FixedPoint_t fx_min, fx_max, fy_min, fy_max;
  int          bx_lo, bx_hi, by_lo, by_hi;
  logic        box_empty, advance, last_col, last_row, pix_on;
  logic [7:0]  ras_r, ras_g, ras_b;

  function automatic int clamp_coord(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  triangle_scan_controller_raster u_raster (
    .i_v1 (v1),
    .i_v2 (v2),
    .i_v3 (v3),
    .i_x  (32'(cur_x)),
    .i_y  (32'(cur_y)),
    .o_r  (ras_r),
    .o_g  (ras_g),
    .o_b  (ras_b)
  );

  // Bounding box of the latched vertices, snapped to integer samples and clamped.
  always_comb begin
    fx_min = v1.x;
    fx_max = v1.x;
    fy_min = v1.y;
    fy_max = v1.y;
    if (v2.x < fx_min) fx_min = v2.x;
    if (v3.x < fx_min) fx_min = v3.x;
    if (v2.x > fx_max) fx_max = v2.x;
    if (v3.x > fx_max) fx_max = v3.x;
    if (v2.y < fy_min) fy_min = v2.y;
    if (v3.y < fy_min) fy_min = v3.y;
    if (v2.y > fy_max) fy_max = v2.y;
    if (v3.y > fy_max) fy_max = v3.y;
    bx_lo = clamp_coord(fixed_point_ceil_int(fx_min), SCREEN_W - 1);
    bx_hi = clamp_coord(fixed_point_floor_int(fx_max), SCREEN_W - 1);
    by_lo = clamp_coord(fixed_point_ceil_int(fy_min), SCREEN_H - 1);
    by_hi = clamp_coord(fixed_point_floor_int(fy_max), SCREEN_H - 1);
    box_empty = (bx_lo > bx_hi) || (by_lo > by_hi);
  end

  // Scan stepping conditions and pixel visibility.
  always_comb begin
    advance  = !o_pixel_valid || i_pixel_ready;
    last_col = (cur_x == xmax);
    last_row = (cur_y == ymax);
    pix_on   = (SKIP_BLACK == 1'b0) || ((ras_r | ras_g | ras_b) != '0);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    o_busy     = (state != S_IDLE);
    o_done     = (state == S_DONE);
    case (state)
      S_IDLE:  if (i_start) state_next = S_SETUP;
      S_SETUP: state_next = box_empty ? S_DONE : S_SCAN;
      S_SCAN:  if (advance && last_col && last_row) state_next = S_DRAIN;
      S_DRAIN: if (!o_pixel_valid || i_pixel_ready) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Vertex latch, cursor walk and output pixel register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      v1            <= '0;
      v2            <= '0;
      v3            <= '0;
      xmin          <= '0;
      xmax          <= '0;
      ymax          <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      o_pixel_valid <= 1'b0;
      o_pixel_x     <= '0;
      o_pixel_y     <= '0;
      o_pixel_r     <= '0;
      o_pixel_g     <= '0;
      o_pixel_b     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            v1 <= '{x: i_v1x, y: i_v1y, r: i_v1r, g: i_v1g, b: i_v1b};
            v2 <= '{x: i_v2x, y: i_v2y, r: i_v2r, g: i_v2g, b: i_v2b};
            v3 <= '{x: i_v3x, y: i_v3y, r: i_v3r, g: i_v3g, b: i_v3b};
          end
        end
        S_SETUP: begin
          xmin  <= xcoord_t'(bx_lo);
          xmax  <= xcoord_t'(bx_hi);
          ymax  <= ycoord_t'(by_hi);
          cur_x <= xcoord_t'(bx_lo);
          cur_y <= ycoord_t'(by_lo);
        end
        S_SCAN: begin
          if (advance) begin
            o_pixel_valid <= pix_on;
            o_pixel_x     <= cur_x;
            o_pixel_y     <= cur_y;
            o_pixel_r     <= ras_r;
            o_pixel_g     <= ras_g;
            o_pixel_b     <= ras_b;
            // Compare before stepping so xmax/ymax are themselves visited.
            if (last_col) begin
              cur_x <= xmin;
              if (!last_row) cur_y <= cur_y + ycoord_t'(1);
            end else begin
              cur_x <= cur_x + xcoord_t'(1);
            end
          end
        end
        S_DRAIN: begin
          if (o_pixel_valid && i_pixel_ready) o_pixel_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
